// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: single-port memory controller behind the SPI slave front-end.
// Decodes 2-bit opcode + payload command words from the rx path, writes and
// reads an internal memory, and returns read data to the tx serialiser.
//
// Opcodes: 00 SET_WADDR, 01 WRITE, 10 SET_RADDR, 11 READ.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   rx_valid  in   din holds a valid command word this cycle
//   din       in   {opcode[1:0], payload[PLD_W-1:0]}
//   dout      out  read data, held until the next READ or reset
//   tx_valid  out  one-cycle pulse per READ, dout is fresh
//   addr_err  out  one-cycle pulse per rejected SET_WADDR/SET_RADDR
//
// Build option: define SPI_MEM_AUTO_INC_EN to post-increment waddr on WRITE and
// raddr on READ (wrapping DEPTH-1 -> 0). Without it, addresses only change on
// SET_WADDR/SET_RADDR.
module spi_mem_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned PLD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [PLD_W+1:0]  din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    OpSetWaddr = 2'b00,
    OpWrite    = 2'b01,
    OpSetRaddr = 2'b10,
    OpRead     = 2'b11
  } op_e;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  op_e               op;
  logic [PLD_W-1:0]  payload;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic              addr_ok;

  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              wr_en;

  assign op      = op_e'(din[PLD_W+1:PLD_W]);
  assign payload = din[PLD_W-1:0];
  assign pl_addr = payload[ADDR_W-1:0];
  assign pl_data = payload[DATA_W-1:0];
  assign addr_ok = {1'b0, pl_addr} < DepthW;

`ifdef SPI_MEM_AUTO_INC_EN
  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    addr_err_d = 1'b0;
    wr_en      = 1'b0;
    if (rx_valid) begin
      unique case (op)
        OpSetWaddr: begin
          if (addr_ok) waddr_d = pl_addr;
          else         addr_err_d = 1'b1;
        end
        OpWrite: begin
          wr_en = 1'b1;
`ifdef SPI_MEM_AUTO_INC_EN
          waddr_d = next_addr(waddr_q);
`endif
        end
        OpSetRaddr: begin
          if (addr_ok) raddr_d = pl_addr;
          else         addr_err_d = 1'b1;
        end
        OpRead: begin
          // Memory write lands at the previous edge, so a READ right after a
          // WRITE to the same word already sees the new data.
          dout_d     = mem[raddr_q];
          tx_valid_d = 1'b1;
`ifdef SPI_MEM_AUTO_INC_EN
          raddr_d = next_addr(raddr_q);
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q    <= '0;
      raddr_q    <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[waddr_q] <= pl_data;
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl (DEPTH=200 to exercise the range check
// and non-power-of-2 wrap). Expected values come from a command-level model:
// an array of words plus two integer addresses.
module tb_spi_mem_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int PLD_W  = 8;
`ifdef SPI_MEM_AUTO_INC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [PLD_W+1:0]  din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              addr_err;

  always #5 clk = ~clk;

  spi_mem_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .din     (din),
    .dout    (dout),
    .tx_valid(tx_valid),
    .addr_err(addr_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state.
  logic [7:0] mm [DEPTH];
  bit         mk [DEPTH];
  int         m_w, m_r;
  logic [7:0] m_dout;
  bit         m_dk, m_tx, m_err;

  // Command encoding for stimulus queues: {rst, rx_valid, opcode, payload}.
  function automatic logic [11:0] c(input bit r, input bit v, input logic [1:0] op,
                                    input logic [7:0] pl);
    return {r, v, op, pl};
  endfunction

  // Drive one cycle at negedge, advance the model, sample 1 time unit after posedge.
  task automatic step(input logic [11:0] cmd);
    bit         r;
    bit         v;
    logic [1:0] op;
    int         pl;
    r  = cmd[11];
    v  = cmd[10];
    op = cmd[9:8];
    pl = int'(cmd[7:0]);
    @(negedge clk);
    rst = r; rx_valid = v; din = {op, cmd[7:0]};
    m_tx = 0; m_err = 0;
    if (r) begin
      m_w = 0; m_r = 0; m_dout = 8'h00; m_dk = 1;
    end else if (v) begin
      case (op)
        2'd0: if (pl < DEPTH) m_w = pl; else m_err = 1;
        2'd1: begin
          mm[m_w] = cmd[7:0]; mk[m_w] = 1;
          if (AutoInc) m_w = (m_w + 1) % DEPTH;
        end
        2'd2: if (pl < DEPTH) m_r = pl; else m_err = 1;
        default: begin
          m_tx = 1; m_dout = mm[m_r]; m_dk = mk[m_r];
          if (AutoInc) m_r = (m_r + 1) % DEPTH;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] q[$];
    q = {c(1, 1, 2'd3, 8'h00), c(1, 1, 2'd3, 8'h00), c(0, 0, 2'd0, 8'h00),
         c(0, 1, 2'd3, 8'h00), c(0, 0, 2'd0, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL reset[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [11:0] q[$];
    q = {c(0, 1, 2'd0, 8'h10), c(0, 1, 2'd1, 8'hA5), c(0, 1, 2'd2, 8'h10),
         c(0, 1, 2'd3, 8'h00), c(0, 0, 2'd0, 8'h00), c(0, 0, 2'd3, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL write_read[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  // Burst across the DEPTH-1 -> 0 wrap (198, 199, 0).
  task automatic test_burst_wrap();
    logic [11:0] q[$];
    q = {c(0, 1, 2'd0, 8'd198), c(0, 1, 2'd1, 8'h11), c(0, 1, 2'd1, 8'h22),
         c(0, 1, 2'd1, 8'h33), c(0, 1, 2'd2, 8'd198), c(0, 1, 2'd3, 8'h00),
         c(0, 1, 2'd3, 8'h00), c(0, 1, 2'd3, 8'h00), c(0, 0, 2'd0, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL burst[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_range();
    logic [11:0] q[$];
    q = {c(0, 1, 2'd0, 8'd20), c(0, 1, 2'd1, 8'h6B), c(0, 1, 2'd2, 8'd20),
         c(0, 1, 2'd2, 8'hC8), c(0, 1, 2'd3, 8'h00), c(0, 1, 2'd0, 8'hFF),
         c(0, 1, 2'd2, 8'd199), c(0, 1, 2'd0, 8'hC7), c(0, 0, 2'd0, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL range[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  // Repeated WRITE/READ at a fixed address, plus write-then-read on consecutive cycles.
  task automatic test_repeat_and_raw();
    logic [11:0] q[$];
    q = {c(0, 1, 2'd0, 8'h06), c(0, 1, 2'd1, 8'h77), c(0, 1, 2'd0, 8'h05),
         c(0, 1, 2'd1, 8'h01), c(0, 1, 2'd1, 8'h02), c(0, 1, 2'd2, 8'h05),
         c(0, 1, 2'd3, 8'h00), c(0, 1, 2'd2, 8'h06), c(0, 1, 2'd3, 8'h00),
         c(0, 1, 2'd0, 8'd40), c(0, 1, 2'd2, 8'd40), c(0, 1, 2'd1, 8'h9C),
         c(0, 1, 2'd3, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL repeat_raw[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [11:0] q[$];
    q = {c(0, 1, 2'd0, 8'd0), c(0, 1, 2'd1, 8'h5A), c(0, 1, 2'd0, 8'd7),
         c(0, 1, 2'd1, 8'hC3), c(0, 1, 2'd2, 8'd7), c(0, 1, 2'd3, 8'h00),
         c(1, 1, 2'd3, 8'h00), c(0, 1, 2'd3, 8'h00)};
    foreach (q[i]) begin
      step(q[i]);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL reset_mid[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [11:0] cmd;
    // Fill every word so random reads always have a known expected value.
    for (int a = 0; a < DEPTH; a++) begin
      step(c(0, 1, 2'd0, 8'(a)));
      step(c(0, 1, 2'd1, 8'($urandom_range(0, 255))));
    end
    for (int i = 0; i < 500; i++) begin
      cmd = c($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      step(cmd);
      n_total++;
      if (tx_valid !== m_tx || addr_err !== m_err || (m_dk && dout !== m_dout))
        $display("FAIL random[%0d]: tx_valid=%b addr_err=%b dout=%h, expected %b %b %h",
                 i, tx_valid, addr_err, dout, m_tx, m_err, m_dout);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; din = '0;
    m_w = 0; m_r = 0; m_dout = 8'h00; m_dk = 0; m_tx = 0; m_err = 0;
    for (int a = 0; a < DEPTH; a++) begin
      mk[a] = 0;
      mm[a] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_range();
    test_repeat_and_raw();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
